fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/select_4.sv | 31 +++
 rtl/fetch_ctrl.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
//==============================================================================
// Module  : cpu_pkg
// Brief   : Shared fetch-stage types: redirect select codes, fetch FSM states,
//           default reset PC.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package cpu_pkg;

  localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    PC_SEQ    = 2'b00,
    PC_BRANCH = 2'b01,
    PC_JREG   = 2'b10,
    PC_JUMP   = 2'b11
  } pc_sel_e;

  typedef enum logic [1:0] {
    FS_BOOT    = 2'b00,
    FS_FETCH   = 2'b01,
    FS_HOLD    = 2'b10,
    FS_DISCARD = 2'b11
  } fetch_state_e;

  // A request is outstanding in FETCH and while draining a stale one in DISCARD.
  function automatic logic fetch_req(input fetch_state_e s);
    return (s == FS_FETCH) || (s == FS_DISCARD);
  endfunction

endpackage

`default_nettype wire

// File: rtl/select_4.sv
//==============================================================================
// Module  : select_4
// Brief   : Generic 4:1 multiplexer indexed by a 2-bit select.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module select_4 #(
  parameter int WIDTH = 32
) (
  input  logic [1:0]       i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  input  logic [WIDTH-1:0] i_d2,
  input  logic [WIDTH-1:0] i_d3,
  output logic [WIDTH-1:0] o_y
);

  always_comb begin
    o_y = i_d0;
    case (i_sel)
      2'b00:   o_y = i_d0;
      2'b01:   o_y = i_d1;
      2'b10:   o_y = i_d2;
      default: o_y = i_d3;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
//==============================================================================
// Module  : fetch_ctrl
// Brief   : Instruction fetch controller with one-entry hold buffer, redirect
//           handling and optional performance counters (macro FETCH_PERF_EN).
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = C_RESET_PC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  pc_select,
  input  logic [31:0] pc_b,
  input  logic [31:0] pc_r,
  input  logic [31:0] pc_j,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_add4,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_discard
);

  fetch_state_e r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_tgt;
  logic [31:0]  r_hold_instr;
  logic [31:0]  r_hold_pc;
  logic         r_if_valid;
  logic [31:0]  r_if_instr;
  logic [31:0]  r_if_pc;
  logic [31:0]  r_if_pc_add4;

  logic [31:0]  w_pc_add4;
  logic [31:0]  w_next_pc;
  logic         w_redirect;

  assign w_pc_add4  = r_pc + 32'd4;
  assign w_redirect = (pc_select != PC_SEQ);

  select_4 #(.WIDTH(32)) u_next_pc (
    .i_sel (pc_select),
    .i_d0  (w_pc_add4),
    .i_d1  (pc_b),
    .i_d2  (pc_r),
    .i_d3  (pc_j),
    .o_y   (w_next_pc)
  );

  // In DISCARD r_pc still holds the address of the in-flight request;
  // the redirect target waits in r_tgt until that request drains.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= FS_BOOT;
      r_pc         <= RESET_PC;
      r_tgt        <= RESET_PC;
      r_hold_instr <= '0;
      r_hold_pc    <= '0;
      r_if_valid   <= 1'b0;
      r_if_instr   <= '0;
      r_if_pc      <= '0;
      r_if_pc_add4 <= '0;
    end else begin
      case (r_state)
        FS_BOOT: begin
          if (w_redirect) begin
            r_pc       <= w_next_pc;
            r_if_valid <= 1'b0;
          end
          r_state <= FS_FETCH;
        end
        FS_FETCH: begin
          if (w_redirect) begin
            r_if_valid <= 1'b0;
            if (imem_ready) begin
              r_pc <= w_next_pc;
            end else begin
              r_tgt   <= w_next_pc;
              r_state <= FS_DISCARD;
            end
          end else if (imem_ready) begin
            r_pc <= w_next_pc;
            if (stall) begin
              r_hold_instr <= imem_rdata;
              r_hold_pc    <= r_pc;
              r_state      <= FS_HOLD;
            end else begin
              r_if_valid   <= 1'b1;
              r_if_instr   <= imem_rdata;
              r_if_pc      <= r_pc;
              r_if_pc_add4 <= w_pc_add4;
            end
          end else if (!stall) begin
            r_if_valid <= 1'b0;
          end
        end
        FS_HOLD: begin
          if (w_redirect) begin
            r_pc       <= w_next_pc;
            r_if_valid <= 1'b0;
            r_state    <= FS_FETCH;
          end else if (!stall) begin
            r_if_valid   <= 1'b1;
            r_if_instr   <= r_hold_instr;
            r_if_pc      <= r_hold_pc;
            r_if_pc_add4 <= r_hold_pc + 32'd4;
            r_state      <= FS_FETCH;
          end
        end
        default: begin
          if (w_redirect) begin
            r_tgt      <= w_next_pc;
            r_if_valid <= 1'b0;
          end
          if (imem_ready) begin
            r_pc    <= w_redirect ? w_next_pc : r_tgt;
            r_state <= FS_FETCH;
          end
        end
      endcase
    end
  end

  assign imem_req   = fetch_req(r_state);
  assign imem_addr  = r_pc;
  assign if_valid   = r_if_valid;
  assign if_instr   = r_if_instr;
  assign if_pc      = r_if_pc;
  assign if_pc_add4 = r_if_pc_add4;

`ifdef FETCH_PERF_EN
  logic        w_deliver;
  logic        w_drop;
  logic [31:0] r_perf_fetch;
  logic [31:0] r_perf_discard;

  assign w_deliver = !w_redirect && !stall &&
                     (((r_state == FS_FETCH) && imem_ready) || (r_state == FS_HOLD));
  assign w_drop    = imem_ready &&
                     (((r_state == FS_FETCH) && w_redirect) || (r_state == FS_DISCARD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_fetch   <= '0;
      r_perf_discard <= '0;
    end else begin
      if (w_deliver) r_perf_fetch   <= r_perf_fetch + 32'd1;
      if (w_drop)    r_perf_discard <= r_perf_discard + 32'd1;
    end
  end

  assign perf_fetch   = r_perf_fetch;
  assign perf_discard = r_perf_discard;
`else
  assign perf_fetch   = '0;
  assign perf_discard = '0;
`endif

endmodule

`default_nettype wire
